// File: rtl/mbist_pkg.sv
// Shared types and constants for the March-style memory BIST controller.
package mbist_pkg;

  localparam int   NUM_BG_DEF = 6;
  localparam int   BG_W       = 3;
  localparam logic INV_ZERO   = 1'b0;
  localparam logic INV_ONE    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0_W,
    ST_M1_R,
    ST_M1_W,
    ST_M2_R,
    ST_M2_W,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with terminal-count flags.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              up,
  input  logic              dn,
  output logic [ADDR_W-1:0] addr,
  output logic              at_min,
  output logic              at_max
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load)
      addr_d = load_val;
    else if (up)
      addr_d = addr_q + ADDR_W'(1);
    else if (dn)
      addr_d = addr_q - ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr   = addr_q;
  assign at_min = (addr_q == '0);
  assign at_max = (addr_q == '1);

endmodule

// File: rtl/mbist_ctrl.sv
// March BIST sequencer: M0 up(w0), M1 up(r0,w1), M2 down(r1,w0) per data background.
// Define MBIST_FAIL_LOG_EN to enable the first-fail address/background log and mismatch counter.
module mbist_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int NUM_BG = NUM_BG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [2:0]        q,
  input  logic [7:0]        data_t,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [7:0]        wr_data,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_q,
  output logic [7:0]        fail_cnt
);

  // states: IDLE idle | M0_W up w0 | M1_R,M1_W up r0,w1 | M2_R,M2_W down r1,w0 | DONE finished
  state_t            state_q, state_d;
  logic [BG_W-1:0]   q_q, q_d;
  logic              we_q, we_d, re_q, re_d, busy_q, busy_d, done_q, done_d, inv_q, inv_d;
  logic              cmp_pend_q, cmp_pend_d, fail_sticky_q, fail_sticky_d;
  logic [7:0]        exp_q, exp_d;
  logic              ag_load, ag_up, ag_dn, at_min, at_max, start_run, mismatch;
  logic [ADDR_W-1:0] addr_w;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val ('0),
    .up       (ag_up),
    .dn       (ag_dn),
    .addr     (addr_w),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  assign mismatch = cmp_pend_q && (rd_data != exp_q);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    ag_load   = 1'b0;
    ag_up     = 1'b0;
    ag_dn     = 1'b0;
    start_run = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d   = ST_M0_W;
        q_d       = '0;
        ag_load   = 1'b1;
        start_run = 1'b1;
      end
      ST_M0_W: if (at_max) begin
        state_d = ST_M1_R;
        ag_load = 1'b1;
      end else begin
        ag_up = 1'b1;
      end
      ST_M1_R: state_d = ST_M1_W;
      ST_M1_W: if (at_max) begin
        state_d = ST_M2_R;
      end else begin
        state_d = ST_M1_R;
        ag_up   = 1'b1;
      end
      ST_M2_R: state_d = ST_M2_W;
      ST_M2_W: if (!at_min) begin
        state_d = ST_M2_R;
        ag_dn   = 1'b1;
      end else if (q_q == BG_W'(NUM_BG - 1)) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_M0_W;
        q_d     = q_q + BG_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    we_d   = (state_d == ST_M0_W) || (state_d == ST_M1_W) || (state_d == ST_M2_W);
    re_d   = (state_d == ST_M1_R) || (state_d == ST_M2_R);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    inv_d  = ((state_d == ST_M1_W) || (state_d == ST_M2_R)) ? INV_ONE : INV_ZERO;

    // expected word is captured in the read cycle, checked against rd_data one cycle later
    exp_d         = re_q ? (data_t ^ {8{inv_q}}) : exp_q;
    cmp_pend_d    = start_run ? 1'b0 : re_q;
    fail_sticky_d = start_run ? 1'b0 : (fail_sticky_q | mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      q_q           <= '0;
      we_q          <= 1'b0;
      re_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      inv_q         <= INV_ZERO;
      exp_q         <= '0;
      cmp_pend_q    <= 1'b0;
      fail_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      we_q          <= we_d;
      re_q          <= re_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      inv_q         <= inv_d;
      exp_q         <= exp_d;
      cmp_pend_q    <= cmp_pend_d;
      fail_sticky_q <= fail_sticky_d;
    end
  end

  assign q       = q_q;
  assign addr    = addr_w;
  assign we      = we_q;
  assign re      = re_q;
  assign wr_data = data_t ^ {8{inv_q}};
  assign busy    = busy_q;
  assign done    = done_q;
  assign fail    = fail_sticky_q;

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
  logic [BG_W-1:0]   cmp_bg_q, cmp_bg_d, fail_bg_q, fail_bg_d;
  logic [7:0]        fail_cnt_q, fail_cnt_d;

  always_comb begin
    cmp_addr_d  = re_q ? addr_w : cmp_addr_q;
    cmp_bg_d    = re_q ? q_q : cmp_bg_q;
    fail_addr_d = fail_addr_q;
    fail_bg_d   = fail_bg_q;
    fail_cnt_d  = fail_cnt_q;
    if (start_run) begin
      fail_addr_d = '0;
      fail_bg_d   = '0;
      fail_cnt_d  = '0;
    end else if (mismatch) begin
      if (!fail_sticky_q) begin
        fail_addr_d = cmp_addr_q;
        fail_bg_d   = cmp_bg_q;
      end
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_addr_q  <= '0;
      cmp_bg_q    <= '0;
      fail_addr_q <= '0;
      fail_bg_q   <= '0;
      fail_cnt_q  <= '0;
    end else begin
      cmp_addr_q  <= cmp_addr_d;
      cmp_bg_q    <= cmp_bg_d;
      fail_addr_q <= fail_addr_d;
      fail_bg_q   <= fail_bg_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_q    = fail_bg_q;
  assign fail_cnt  = fail_cnt_q;
`else
  assign fail_addr = '0;
  assign fail_q    = '0;
  assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_mbist_ctrl.sv
// Directed bench for mbist_ctrl: table of full runs with memory faults, plus reset/hold sequences.
module tb_mbist_ctrl;
  localparam int DEPTH   = 16;
  localparam int NUM_BG  = 6;
  localparam int RUN_CYC = 480;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] q, fail_q;
  logic [7:0] data_t, wr_data, rd_data, fail_cnt;
  logic [3:0] addr, fail_addr;
  logic       we, re, busy, done, fail;

  mbist_ctrl #(.ADDR_W(4), .NUM_BG(NUM_BG)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .data_t(data_t), .addr(addr),
    .we(we), .re(re), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .fail(fail), .fail_addr(fail_addr), .fail_q(fail_q), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bg_pat(input int b);
    case (b)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h55;
      3: return 8'hAA;
      4: return 8'h33;
      5: return 8'hCC;
      default: return 8'h0F;
    endcase
  endfunction

  assign data_t = bg_pat(int'(q));

  // memory with one optional stuck-at cell bit (type 1 = sa1, 2 = sa0), optionally only for one background
  logic [7:0] mem [DEPTH];
  int f_type = 0, f_addr = 0, f_bit = 0, f_q = -1;

  function automatic logic [7:0] read_word(input logic [3:0] a, input logic [2:0] qq);
    logic [7:0] v;
    v = mem[a];
    if (f_type != 0 && int'(a) == f_addr && (f_q < 0 || int'(qq) == f_q))
      v[f_bit] = (f_type == 1);
    return v;
  endfunction

  always @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
    if (re) rd_data <= read_word(addr, q);
  end

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [2:0] q;
    logic [7:0] wd;
  } step_t;
  step_t trace[$];

  typedef struct {
    string name;
    int    f_type, f_addr, f_bit, f_q, start_at;
    int    exp_fail, exp_faddr, exp_fq, exp_fcnt;
  } vec_t;
  vec_t vecs[6];

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void push(input logic w, input logic r, input int a, input int b, input logic [7:0] d);
    step_t s;
    s.we = w; s.re = r; s.addr = 4'(a); s.q = 3'(b); s.wd = d;
    trace.push_back(s);
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, busy_n, err, done_cyc;
    f_type = v.f_type; f_addr = v.f_addr; f_bit = v.f_bit; f_q = v.f_q;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1; busy_n = 0; err = 0; done_cyc = 0;
    while (cyc <= 2000) begin
      if (busy) begin
        if (busy_n < RUN_CYC) begin
          if (we !== trace[busy_n].we || re !== trace[busy_n].re || addr !== trace[busy_n].addr ||
              q !== trace[busy_n].q || (trace[busy_n].we && wr_data !== trace[busy_n].wd)) begin
            if (err < 3) $display("trace diff %s step %0d: we=%b re=%b addr=%0d q=%0d wd=%h", v.name,
                                  busy_n, we, re, addr, q, wr_data);
            err++;
          end
        end
        busy_n++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == v.start_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({v.name, " busy_cycles"}, busy_n, RUN_CYC);
    check({v.name, " done_cycle"}, done_cyc, RUN_CYC + 1);
    check({v.name, " trace"}, err, 0);
    check({v.name, " fail"}, fail, v.exp_fail);
`ifdef MBIST_FAIL_LOG_EN
    check({v.name, " fail_addr"}, fail_addr, v.exp_faddr);
    check({v.name, " fail_q"}, fail_q, v.exp_fq);
    check({v.name, " fail_cnt"}, fail_cnt, v.exp_fcnt);
`else
    check({v.name, " fail_addr"}, fail_addr, 0);
    check({v.name, " fail_q"}, fail_q, 0);
    check({v.name, " fail_cnt"}, fail_cnt, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, type, addr, bit, q-only, start_at, fail, faddr, fq, fcnt
    vecs[0] = '{"clean",      0,  0, 0, -1,  0, 0,  0, 0, 0};
    vecs[1] = '{"sa1_a5_b0",  1,  5, 0, -1,  0, 1,  5, 0, 6};
    vecs[2] = '{"start_mid",  0,  0, 0, -1, 50, 0,  0, 0, 0};
    vecs[3] = '{"sa0_a9_b0",  2,  9, 0, -1,  0, 1,  9, 0, 6};
    vecs[4] = '{"sa1_a15_b7", 1, 15, 7, -1,  0, 1, 15, 0, 6};
    vecs[5] = '{"last_read",  1,  0, 7,  5,  0, 1,  0, 5, 1};

    for (int b = 0; b < NUM_BG; b++) begin
      for (int a = 0; a < DEPTH; a++) push(1'b1, 1'b0, a, b, bg_pat(b));
      for (int a = 0; a < DEPTH; a++) begin
        push(1'b0, 1'b1, a, b, 8'h00);
        push(1'b1, 1'b0, a, b, ~bg_pat(b));
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
        push(1'b0, 1'b1, a, b, 8'h00);
        push(1'b1, 1'b0, a, b, bg_pat(b));
      end
    end

    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fail", fail, 0);
    check("reset we_re", {we, re}, 0);
    check("reset addr_q", {addr, q}, 0);
    check("reset log", {fail_addr, fail_q, fail_cnt}, 0);
    check("reset wr_data", wr_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    repeat (5) @(negedge clk);
    check("hold done", done, 1);
    check("hold busy", busy, 0);
    check("hold we_re", {we, re}, 0);
    check("hold q", q, NUM_BG - 1);

    // reset in the middle of a faulty run, then a clean rerun
    f_type = 1; f_addr = 5; f_bit = 0; f_q = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (199) @(negedge clk);
    check("pre_rst busy", busy, 1);
    check("pre_rst fail", fail, 1);
    rst = 1'b1;
    #1;
    check("midrst busy_done_fail", {busy, done, fail}, 0);
    check("midrst we_re", {we, re}, 0);
    check("midrst addr_q", {addr, q}, 0);
    check("midrst log", {fail_addr, fail_q, fail_cnt}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mbist_ctrl.md
MBIST_CTRL -- requirements
Module: mbist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; depth is 2**ADDR_W.
REQ-002 Parameter NUM_BG, default 6, number of data backgrounds run, q = 0..NUM_BG-1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  run request, sampled in IDLE or DONE only.
REQ-006 q  output  3  background select driven to the pattern decoder.
REQ-007 data_t  input  8  background pattern returned by the decoder for current q.
REQ-008 addr  output  ADDR_W  memory address.
REQ-009 we / re  output  1 each  memory write / read strobe, never both high.
REQ-010 wr_data  output  8  data_t XOR {8{inv}}, inv = current element polarity.
REQ-011 rd_data  input  8  memory read data, valid exactly 1 cycle after re.
REQ-012 busy, done, fail  output  1 each  running, finished (level), sticky mismatch.
REQ-013 fail_addr  output  ADDR_W, fail_q  output  3, fail_cnt  output  8  first-fail log.

Function
REQ-014 FSM states: IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, DONE.
REQ-015 Per background: M0 up(w0); M1 up(r0,w1); M2 down(r1,w0); "0" = data_t, "1" = ~data_t.
REQ-016 IDLE/DONE + start=1 -> M0_W next cycle, addr=0, q=0, fail and log cleared, busy=1.
REQ-017 M0_W: one write per cycle, addr 0..max; at max -> M1_R, addr=0.
REQ-018 M1: R then W on same addr, addr++ after W; at max W -> M2_R, addr=max.
REQ-019 M2: R then W on same addr, addr-- after W; at addr 0 W -> q+1, M0_W, addr=0, or DONE if q=NUM_BG-1.
REQ-020 Compare: expected = data_t XOR inv latched with re; rd_data compared the following cycle; mismatch sets fail.
REQ-021 Run length: 5*2**ADDR_W cycles per background; with defaults busy high exactly 480 cycles, done rises cycle 481.
REQ-022 DONE: done=1, busy=0, we=re=0, q holds last value; stays until start or rst.
REQ-023 start while busy is ignored; addr counter wraps never (terminal counts gate transitions).
REQ-024 Final M2 read compare lands in the last M2_W cycle; DONE entry reflects it in fail.

Reset
REQ-025 rst=1 at any time, including mid-run: state IDLE, q=0, addr=0, we=re=busy=done=fail=0, log=0, pending compare discarded.

Configuration
REQ-026 MBIST_FAIL_LOG_EN defined: fail_addr/fail_q capture first mismatch, fail_cnt counts mismatches saturating at 255.
REQ-027 MBIST_FAIL_LOG_EN undefined: fail_addr, fail_q, fail_cnt tied to 0; fail still operates.

Structure
REQ-028 Package mbist_pkg holds the state enum, NUM_BG default, BG width (3), and the polarity constants.
REQ-029 Sub-module mbist_addr_gen: up/down loadable counter with at_min/at_max flags.

Verification
REQ-030 Fault-free memory model, defaults, start pulse -> 480 busy cycles, done=1, fail=0, q visited 0..5.
REQ-031 Stuck-at-1 bit0 at addr 5 -> fail=1; log on: fail_addr=5, fail_q=0, fail_cnt>=1.
REQ-032 rst asserted at cycle 200 -> all outputs 0 same cycle; new start reruns full 480 cycles cleanly.
REQ-033 start pulsed at cycle 50 of a run -> no effect, run completes at cycle 481.
REQ-034 Check addr sequence per background: 0..15 write, 0..15 r/w pairs, 15..0 r/w pairs; wr_data polarity per REQ-015.
REQ-035 Build without MBIST_FAIL_LOG_EN, inject fault -> fail=1, fail_addr=fail_q=fail_cnt=0.
